// File: rtl/cache_types.sv
// Shared types for the cache controller: mux selects, FSM states, counter width.
package cache_types;

    typedef enum logic [1:0] {
        ALL_DIS = 2'd0,
        ALL_EN  = 2'd1,
        CPU_EN  = 2'd2
    } write_en_sel_t;

    typedef enum logic {
        CPU_DATA = 1'b0,
        RAM_DATA = 1'b1
    } write_data_sel_t;

    typedef enum logic {
        CPU_ADDR = 1'b0,
        TAG_ADDR = 1'b1
    } ram_addr_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    localparam int CNT_W = 32;

endpackage

// File: rtl/cache_ctrl_plru.sv
// Tree pseudo-LRU for one set: heap-ordered node bits, 0 = LRU side is left.
module plru_tree #(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] i_tree,
    input  logic [WAY_W-1:0]    i_way,
    output logic [NUM_WAYS-2:0] o_tree,
    output logic [WAY_W-1:0]    o_victim
);

    always_comb begin
        int   node;
        logic b;
        o_tree = i_tree;
        node   = 0;
        // Walk the accessed way's path, pointing every node away from it
        for (int l = 0; l < WAY_W; l++) begin
            b            = i_way[WAY_W-1-l];
            o_tree[node] = ~b;
            node         = 2 * node + 1 + int'(b);
        end
    end

    always_comb begin
        int   node;
        logic b;
        o_victim = '0;
        node     = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b                   = i_tree[node];
            o_victim[WAY_W-1-l] = b;
            node                = 2 * node + 1 + int'(b);
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// N-way write-back/write-allocate cache control FSM with per-set tree PLRU.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_ctrl
    import cache_types::*;
#(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 8,
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [SET_W-1:0]    set_idx,
    input  logic [NUM_WAYS-1:0] hit_way,
    input  logic [NUM_WAYS-1:0] valid_way,
    input  logic [NUM_WAYS-1:0] dirty_way,
    input  logic                mem_resp,
    output logic                cpu_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [NUM_WAYS-1:0] way_sel,
    output write_en_sel_t       write_en_sel,
    output write_data_sel_t     write_data_sel,
    output ram_addr_sel_t       ram_addr_sel,
    output logic                load_tag,
    output logic                set_valid,
    output logic                set_dirty,
    output logic                clr_dirty
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
`endif
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    cache_state_t        r_state;
    cache_state_t        w_next;
    logic [NUM_WAYS-2:0] r_plru [NUM_SETS];
    logic [NUM_WAYS-1:0] r_victim;
    logic [NUM_WAYS-1:0] w_vic_oh;
    logic [NUM_WAYS-2:0] w_plru_upd;
    logic [WAY_W-1:0]    w_plru_vic;
    logic [WAY_W-1:0]    w_hit_idx;
    logic                w_hit;
    logic                w_vic_dirty;

    assign w_hit       = |hit_way;
    assign w_vic_dirty = |(w_vic_oh & valid_way & dirty_way);

    always_comb begin
        w_hit_idx = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (hit_way[w]) w_hit_idx = WAY_W'(w);
    end

    // Lowest invalid way wins; PLRU only decides when the set is full
    always_comb begin
        w_vic_oh             = '0;
        w_vic_oh[w_plru_vic] = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_way[w]) begin
                w_vic_oh    = '0;
                w_vic_oh[w] = 1'b1;
            end
        end
    end

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .i_tree   (r_plru[set_idx]),
        .i_way    (w_hit_idx),
        .o_tree   (w_plru_upd),
        .o_victim (w_plru_vic)
    );

    always_comb begin
        w_next         = r_state;
        cpu_resp       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        way_sel        = '0;
        write_en_sel   = ALL_DIS;
        write_data_sel = CPU_DATA;
        ram_addr_sel   = CPU_ADDR;
        load_tag       = 1'b0;
        set_valid      = 1'b0;
        set_dirty      = 1'b0;
        clr_dirty      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cpu_read || cpu_write) w_next = COMPARE;
            end
            COMPARE: begin
                if (w_hit) begin
                    cpu_resp = 1'b1;
                    way_sel  = hit_way;
                    if (cpu_write) begin
                        write_en_sel = CPU_EN;
                        set_dirty    = 1'b1;
                    end
                    w_next = IDLE;
                end else begin
                    w_next = w_vic_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write    = 1'b1;
                ram_addr_sel = TAG_ADDR;
                way_sel      = r_victim;
                if (mem_resp) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read       = 1'b1;
                write_data_sel = RAM_DATA;
                way_sel        = r_victim;
                if (mem_resp) begin
                    write_en_sel = ALL_EN;
                    load_tag     = 1'b1;
                    set_valid    = 1'b1;
                    clr_dirty    = 1'b1;
                    w_next       = COMPARE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_victim <= '0;
            for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == COMPARE && !w_hit) r_victim <= w_vic_oh;
            if (r_state == COMPARE && w_hit) r_plru[set_idx] <= w_plru_upd;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic             r_refill;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Marks the re-compare after a fill so it is not counted as a hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refill <= (r_state == ALLOCATE) && mem_resp;
            if (r_state == COMPARE) begin
                if (w_hit && !r_refill && r_hit_cnt != '1)
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                if (!w_hit && r_miss_cnt != '1)
                    r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: driver queues expectations, monitor checks.
module tb_cache_ctrl;
    import cache_types::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cpu_read, cpu_write, mem_resp;
    logic [2:0]      set_idx;
    logic [3:0]      hit_way, valid_way, dirty_way;
    logic            cpu_resp, mem_read, mem_write;
    logic [3:0]      way_sel;
    write_en_sel_t   write_en_sel;
    write_data_sel_t write_data_sel;
    ram_addr_sel_t   ram_addr_sel;
    logic            load_tag, set_valid, set_dirty, clr_dirty;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]     hit_count, miss_count;
`endif

    cache_ctrl #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .set_idx        (set_idx),
        .hit_way        (hit_way),
        .valid_way      (valid_way),
        .dirty_way      (dirty_way),
        .mem_resp       (mem_resp),
        .cpu_resp       (cpu_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .way_sel        (way_sel),
        .write_en_sel   (write_en_sel),
        .write_data_sel (write_data_sel),
        .ram_addr_sel   (ram_addr_sel),
        .load_tag       (load_tag),
        .set_valid      (set_valid),
        .set_dirty      (set_dirty),
        .clr_dirty      (clr_dirty)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] way;
        logic       wr;
        int         lat;
    } rsp_t;

    typedef struct {
        logic       wb;
        logic [3:0] way;
    } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   cyc    = 0;
    int   t_req  = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        rsp_t r;
        mem_t m;
        if (rst_n) begin
            chk("resp_vs_mem", {31'd0, cpu_resp && (mem_read || mem_write)}, 0);
            if (cpu_resp) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got way_sel %0h expected none", way_sel);
                end else begin
                    r = rsp_q.pop_front();
                    chk("resp_way", 32'(way_sel), 32'(r.way));
                    chk("resp_wen", 32'(write_en_sel), r.wr ? 32'(CPU_EN) : 32'(ALL_DIS));
                    chk("resp_dirty", 32'(set_dirty), 32'(r.wr));
                    chk("resp_wdata", 32'(write_data_sel), 32'(CPU_DATA));
                    chk("resp_lat", cyc - t_req, r.lat);
                end
            end
            if ((mem_read || mem_write) && mem_q.size() != 0) begin
                chk("mem_way", 32'(way_sel), 32'(mem_q[0].way));
                chk("mem_kind", 32'({mem_write, mem_read}),
                    mem_q[0].wb ? 32'd2 : 32'd1);
            end
            if (mem_resp && (mem_read || mem_write)) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem: got rd %0b wr %0b expected none", mem_read, mem_write);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", 32'(ram_addr_sel), m.wb ? 32'(TAG_ADDR) : 32'(CPU_ADDR));
                    chk("mem_wdata", 32'(write_data_sel), m.wb ? 32'(CPU_DATA) : 32'(RAM_DATA));
                    chk("mem_wen", 32'(write_en_sel), m.wb ? 32'(ALL_DIS) : 32'(ALL_EN));
                    chk("mem_strobes", 32'({load_tag, set_valid, clr_dirty, set_dirty}),
                        m.wb ? 32'd0 : 32'he);
                end
            end
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [2:0] set,
                       input logic [3:0] hit, input logic [3:0] vld,
                       input logic [3:0] drt, input logic [3:0] vic,
                       input int wb_lat, input int al_lat);
        rsp_t r;
        mem_t m;
        bit   miss, dv, done;
        int   wc, ac;
        miss  = (hit == 4'b0);
        dv    = miss && ((vic & vld & drt) != 4'b0);
        r.way = miss ? vic : hit;
        r.wr  = wr;
        r.lat = miss ? 2 + (dv ? wb_lat : 0) + al_lat : 1;
        if (dv) begin
            m.wb = 1'b1; m.way = vic; mem_q.push_back(m);
        end
        if (miss) begin
            m.wb = 1'b0; m.way = vic; mem_q.push_back(m);
        end
        rsp_q.push_back(r);
        @(posedge clk); #1;
        set_idx = set; cpu_read = rd; cpu_write = wr;
        hit_way = hit; valid_way = vld; dirty_way = drt;
        t_req = cyc;
        done = 0; wc = 0; ac = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (cpu_resp) done = 1;
            else if (mem_write) begin
                wc++;
                if (wc == wb_lat) mem_resp = 1'b1;
            end else if (mem_read) begin
                ac++;
                if (ac == al_lat) begin
                    mem_resp = 1'b1;
                    hit_way  = vic;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no cpu_resp expected one within 100 cycles (set %0d)", set);
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0; hit_way = 4'b0; mem_resp = 1'b0;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; cpu_read = 0; cpu_write = 0; mem_resp = 0;
        set_idx = 0; hit_way = 0; valid_way = 0; dirty_way = 0;
        #1;
        chk("rst_cpu_resp", 32'(cpu_resp), 0);
        chk("rst_mem", 32'({mem_read, mem_write}), 0);
        chk("rst_way_sel", 32'(way_sel), 0);
        chk("rst_wen", 32'(write_en_sel), 32'(ALL_DIS));
        chk("rst_sel", 32'({write_data_sel, ram_addr_sel}), 0);
        #20 rst_n = 1'b1;

        req(1, 0, 3, 4'b0100, 4'hF, 4'h0, 4'h0, 0, 0);
        req(0, 1, 3, 4'b0001, 4'hF, 4'h0, 4'h0, 0, 0);
        req(1, 0, 3, 4'b0000, 4'hF, 4'h0, 4'b1000, 0, 2);
        req(0, 1, 5, 4'b0000, 4'b0111, 4'b1000, 4'b1000, 0, 5);
        req(1, 0, 1, 4'b0000, 4'hF, 4'hF, 4'b0001, 3, 2);
        req(1, 1, 3, 4'b0010, 4'hF, 4'h0, 4'h0, 0, 0);
        req(1, 0, 3, 4'b0000, 4'hF, 4'b1011, 4'b0100, 0, 1);
        req(1, 0, 3, 4'b0001, 4'hF, 4'h0, 4'h0, 0, 0);

        @(posedge clk); #1;
        set_idx = 3; cpu_read = 1; hit_way = 0; valid_way = 4'hF; dirty_way = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (mem_read) seen = 1;
        end
        chk("abort_reach_alloc", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_read", 32'({mem_read, mem_write}), 0);
        chk("abort_way_sel", 32'(way_sel), 0);
        cpu_read = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_resp = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        chk("stray_resp", 32'({cpu_resp, mem_read, mem_write}), 0);
        @(posedge clk); #1;
        chk("stray_idle", 32'({cpu_resp, mem_read, mem_write}), 0);

        req(1, 0, 3, 4'b0000, 4'hF, 4'h0, 4'b0001, 0, 3);

`ifdef CACHE_PERF_CNT_EN
        req(1, 0, 2, 4'b0000, 4'b0011, 4'h0, 4'b0100, 0, 1);
        req(1, 0, 0, 4'b1000, 4'hF, 4'h0, 4'h0, 0, 0);
        req(0, 1, 4, 4'b0010, 4'hF, 4'h0, 4'h0, 0, 0);
        req(1, 0, 6, 4'b0100, 4'hF, 4'h0, 4'h0, 0, 0);
        #1;
        chk("hit_count", hit_count, 32'd3);
        chk("miss_count", miss_count, 32'd2);
        dut.r_hit_cnt = 32'hFFFF_FFFE;
        req(1, 0, 0, 4'b0001, 4'hF, 4'h0, 4'h0, 0, 0);
        req(1, 0, 0, 4'b0001, 4'hF, 4'h0, 4'h0, 0, 0);
        #1;
        chk("hit_count_sat", hit_count, 32'hFFFF_FFFF);
`endif

        @(posedge clk); #1;
        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("mem_q_empty", mem_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
